byte_decrypt_engine: RTL
========================

# byte_decrypt_engine

Iterative 8-bit decryption core: the receive-side inverse of the team's rotate-right/XOR byte cipher. It accepts one ciphertext byte and an 8-bit key over a valid/ready handshake and runs ROUNDS inverse rounds, one per clock. It returns the plaintext byte over a second valid/ready handshake. It sits between the UART/byte-receive path and the plaintext consumer on the FPGA.

## Interface
- ROUNDS, 4, number of cipher rounds; legal range 1..16; must match the encryptor setting.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key  input  8  master key, sampled only on input handshake.
- in_valid  input  1  ciphertext byte present.
- in_ready  output  1  engine can accept a byte.
- in_data  input  8  ciphertext byte.
- out_valid  output  1  plaintext byte present.
- out_ready  input  1  consumer accepts the byte.
- out_data  output  8  plaintext byte.
- busy  output  1  high in RUN or DONE.

## Operation
- Cipher definition (encrypt, for reference in the model): for r = 0..ROUNDS-1, c = rotr1(c ^ k_r), where k_r = rotr(key, r mod 8).
- Decrypt: for r = ROUNDS-1 down to 0, p = rotl1(p) ^ k_r.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the data register and key into the key register. Load the round counter with ROUNDS-1, then go to RUN.
  - RUN: each cycle, data <= rotl1(data) ^ rotr(key_reg, rnd). If rnd==0, go to DONE; otherwise rnd <= rnd-1.
  - DONE: out_valid=1 and out_data=data register, both held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored, and the producer must hold its data.
- key changes after the handshake have no effect on the byte in flight.
- Round counter width is 4 bits. The round-key rotation amount is rnd[2:0]: rotation wraps mod 8.
- All data arithmetic is 8-bit with no carries. XOR and rotate are width-preserving.
- Reset mid-operation: state goes to IDLE immediately and the in-flight byte is discarded. No out_valid follows.

## Timing
- Reset values: in_ready=1 once rst_n is released (in_ready=0 while rst_n is low), out_valid=0, out_data=0x00, busy=0. The internal data, key and counter registers reset to 0.
- Input handshake at edge N leads to out_valid=1 after edge N+ROUNDS, so latency is ROUNDS cycles.
- Output handshake at edge M leads to in_ready=1 after edge M.
- Minimum spacing between accepted bytes is ROUNDS+2 cycles.
- Back-pressure: out_ready=0 holds DONE indefinitely with out_data stable.
- out_valid does not depend combinationally on out_ready. in_ready does not depend combinationally on in_valid.

## Structure
- Shared header crypto_defs.vh holds:
  - DATA_W=8;
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default ROUNDS, shared with the encryptor.
- Sub-module circular_left_shift (8-bit combinational rotl1) is instantiated for the round datapath.
- The round-key rotate uses an inline barrel rotate by rnd[2:0].

## Test plan
- ROUNDS=1, key=0xA5, in_data=0xCC -> out_data=0x3C, with out_valid asserted exactly 1 cycle after the input handshake.
- ROUNDS=4: 256 random key/plaintext pairs are encrypted by the model and fed in -> every out_data equals the original plaintext, with latency 4 each.
- Back-pressure: out_ready held 0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout; a second in_valid during that time is not accepted.
- Key change: key switches from 0x5A to 0xFF one cycle after the handshake -> result still decrypted with 0x5A.
- Reset mid-RUN: rst_n pulsed low at round 2 -> out_valid stays 0, in_ready=1 after release, and the next byte decrypts correctly.
- Wrap check: ROUNDS=16, key=0x81 -> round-key rotation wraps mod 8, and the round-trip against the model passes.

Source files
------------

// File: rtl/byte_decrypt_engine_pkg.sv
// Shared definitions for the byte cipher receive path: widths, default round
// count (must agree with the encryptor) and the decrypt FSM state encoding.
package byte_decrypt_engine_pkg;

  localparam int unsigned DataW         = 8;
  localparam int unsigned CntW          = 4;
  localparam int unsigned DefaultRounds = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/circular_left_shift.sv
// Single-position left rotate of a data byte; undoes the encryptor's rotr1.
module circular_left_shift
  import byte_decrypt_engine_pkg::*;
(
  input  logic [DataW-1:0] data_i,
  output logic [DataW-1:0] data_o
);

  // MSB wraps around into the LSB
  assign data_o = {data_i[DataW-2:0], data_i[DataW-1]};

endmodule

// File: rtl/byte_decrypt_engine.sv
// Iterative inverse of the rotate-right/XOR byte cipher. One inverse round per
// clock, counting the round index down from ROUNDS-1 to 0.
module byte_decrypt_engine
  import byte_decrypt_engine_pkg::*;
#(
  parameter int unsigned ROUNDS = DefaultRounds
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DataW-1:0] key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DataW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DataW-1:0] out_data,
  output logic             busy
);

  localparam logic [CntW-1:0] RndInit = CntW'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [DataW-1:0] data_q, data_d;
  logic [DataW-1:0] key_q, key_d;
  logic [CntW-1:0]  rnd_q, rnd_d;

  logic [DataW-1:0] data_rotl;
  logic [DataW-1:0] rk_s0, rk_s1, round_key;
  logic [DataW-1:0] round_out;
  logic             in_ready_fsm;

  circular_left_shift u_rotl (
    .data_i (data_q),
    .data_o (data_rotl)
  );

  // Round key = key_q rotated right by rnd[2:0]; three-stage barrel, wraps mod 8
  always_comb begin
    rk_s0     = rnd_q[0] ? {key_q[0],   key_q[DataW-1:1]} : key_q;
    rk_s1     = rnd_q[1] ? {rk_s0[1:0], rk_s0[DataW-1:2]} : rk_s0;
    round_key = rnd_q[2] ? {rk_s1[3:0], rk_s1[DataW-1:4]} : rk_s1;
  end

  assign round_out = data_rotl ^ round_key;

  // Next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    key_d        = key_q;
    rnd_d        = rnd_q;
    in_ready_fsm = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_fsm = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          key_d   = key;
          rnd_d   = RndInit;
          state_d = StRun;
        end
      end
      StRun: begin
        busy   = 1'b1;
        data_d = round_out;
        if (rnd_q == '0) begin
          state_d = StDone;
        end else begin
          rnd_d = rnd_q - 1'b1;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Hold off acceptance while reset is asserted, even though the FSM sits in idle
  assign in_ready = in_ready_fsm & rst_n;
  assign out_data = data_q;

  // State, data, key and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule
